// File: rtl/fifo_pkt_arbiter_pkg.sv
// Shared types and constants for the two-port packet round-robin arbiter.
package fifo_pkt_arbiter_pkg;

  localparam int NPORTS      = 2;
  localparam int LEN_W       = 8;
  localparam int MAX_LEN_DEF = 16;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT,
    ST_XFER,
    ST_DROP
  } state_e;

endpackage

// File: rtl/fifo_pkt_arbiter_if.sv
// Bundle of the two FIFO read ports and the outbound byte stream of the arbiter.
interface fifo_pkt_arbiter_if;
  import fifo_pkt_arbiter_pkg::*;

  logic [NPORTS-1:0][LEN_W-1:0] fifo_data;
  logic [NPORTS-1:0]            fifo_avail;
  logic [NPORTS-1:0][LEN_W-1:0] fifo_avail_cnt;
  logic [NPORTS-1:0]            fifo_strobe;

  logic [LEN_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sop;
  logic             out_eop;
  logic             out_port;
  logic             busy;
  logic             pkt_done;
  logic             err;

  modport master (
    input  fifo_data, fifo_avail, fifo_avail_cnt, out_ready,
    output fifo_strobe, out_data, out_valid, out_sop, out_eop, out_port,
           busy, pkt_done, err
  );

  modport slave (
    output fifo_data, fifo_avail, fifo_avail_cnt, out_ready,
    input  fifo_strobe, out_data, out_valid, out_sop, out_eop, out_port,
           busy, pkt_done, err
  );

endinterface

// File: rtl/fifo_pkt_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on contention the port not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  always_comb begin
    grant_valid_o = |req_i;
    if (req_i == 2'b11) grant_o = ~last_grant_i;
    else                grant_o = req_i[1];
  end

endmodule

// File: rtl/fifo_pkt_arbiter.sv
// Packet-granular round-robin scheduler sharing one byte sink between two FIFOs.
// Optional macro FIFO_PKT_ARBITER_CUT_THROUGH_EN: stream without waiting for full residency.
module fifo_pkt_arbiter
  import fifo_pkt_arbiter_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input logic                clk,
  input logic                rst,
  fifo_pkt_arbiter_if.master bus
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   last_grant_q, last_grant_d;
  len_t   len_q, len_d;
  len_t   rem_q, rem_d;
  len_t   out_data_q, out_data_d;
  logic   out_valid_q, out_valid_d;
  logic   out_sop_q, out_sop_d;
  logic   out_eop_q, out_eop_d;

  logic grant, grant_valid;
  len_t cur_data, cur_cnt;
  logic cur_avail;
  logic hdr_zero, load, accept, drop_pop;

  rr_arb2 u_arb (
    .req_i        (bus.fifo_avail),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_valid_o(grant_valid)
  );

  assign cur_data  = bus.fifo_data[sel_q];
  assign cur_cnt   = bus.fifo_avail_cnt[sel_q];
  assign cur_avail = bus.fifo_avail[sel_q];
  assign hdr_zero  = (cur_data == '0);
  assign accept    = out_valid_q & bus.out_ready;
  assign drop_pop  = (state_q == ST_DROP) & cur_avail & (rem_q != '0);

`ifdef FIFO_PKT_ARBITER_CUT_THROUGH_EN
  // Payload may still be arriving, so each load also needs a byte at the head.
  assign load = (state_q == ST_XFER) & (~out_valid_q | bus.out_ready) &
                (rem_q != '0) & cur_avail;
`else
  logic hdr_long;
  assign hdr_long = (cur_data > len_t'(MAX_LEN));
  assign load = (state_q == ST_XFER) & (~out_valid_q | bus.out_ready) &
                (rem_q != '0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      rem_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    rem_d        = rem_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          sel_d   = grant;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        len_d = cur_data;
        rem_d = cur_data;
        if (hdr_zero) begin
          last_grant_d = sel_q;
          state_d      = ST_IDLE;
        end
`ifdef FIFO_PKT_ARBITER_CUT_THROUGH_EN
        else state_d = ST_XFER;
`else
        else if (hdr_long) state_d = ST_DROP;
        else               state_d = ST_WAIT;
`endif
      end
      ST_WAIT: begin
        if (cur_cnt >= rem_q) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (load) begin
          out_data_d  = cur_data;
          out_valid_d = 1'b1;
          out_sop_d   = (rem_q == len_q);
          out_eop_d   = (rem_q == len_t'(1));
          rem_d       = rem_q - len_t'(1);
        end else if (accept) begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
        end
        if (accept && out_eop_q) begin
          last_grant_d = sel_q;
          state_d      = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (rem_q == '0) begin
          last_grant_d = sel_q;
          state_d      = ST_IDLE;
        end else if (drop_pop) begin
          rem_d = rem_q - len_t'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.fifo_strobe = '0;
    bus.pkt_done    = 1'b0;
    bus.err         = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        bus.fifo_strobe[sel_q] = 1'b1;
        bus.pkt_done           = hdr_zero;
`ifndef FIFO_PKT_ARBITER_CUT_THROUGH_EN
        bus.err                = ~hdr_zero & hdr_long;
`endif
      end
      ST_XFER: begin
        bus.fifo_strobe[sel_q] = load;
        bus.pkt_done           = accept & out_eop_q;
      end
      ST_DROP: begin
        bus.fifo_strobe[sel_q] = drop_pop;
        bus.pkt_done           = (rem_q == '0);
      end
      default: ;
    endcase
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_port  = sel_q;
  assign bus.busy      = (state_q != ST_IDLE) | out_valid_q;

endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// Scoreboard bench for fifo_pkt_arbiter with two queue-backed FIFO models.
module tb_fifo_pkt_arbiter;
  import fifo_pkt_arbiter_pkg::*;

  localparam int MAXL = 16;

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  fifo_pkt_arbiter_if bus ();

  fifo_pkt_arbiter #(.MAX_LEN(MAXL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  beat_t      exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, nacc = 0, first_acc = 0, last_acc = 0;
  int n_done = 0, n_err = 0, pops0 = 0, pops1 = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_avail        = {fq1.size() != 0, fq0.size() != 0};
    bus.fifo_data[0]      = (fq0.size() != 0) ? fq0[0] : 8'h00;
    bus.fifo_data[1]      = (fq1.size() != 0) ? fq1[0] : 8'h00;
    bus.fifo_avail_cnt[0] = (fq0.size() > 255) ? 8'hFF : 8'(fq0.size());
    bus.fifo_avail_cnt[1] = (fq1.size() > 255) ? 8'hFF : 8'(fq1.size());
  endtask

  task automatic push_byte(input logic p, input logic [7:0] d);
    if (p) fq1.push_back(d);
    else   fq0.push_back(d);
  endtask

  task automatic push_pkt(input logic p, input int len, input logic [7:0] base,
                          input int npay, input logic expect_out);
    beat_t b;
    push_byte(p, 8'(len));
    for (int i = 0; i < npay; i++) push_byte(p, base + 8'(i));
    if (expect_out) begin
      for (int i = 0; i < len; i++) begin
        b.port = p;
        b.data = base + 8'(i);
        b.sop  = (i == 0);
        b.eop  = (i == len - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Evaluated just before a rising edge, with the bench inputs already final.
  task automatic mon();
    beat_t b;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_beat", 32'(bus.out_valid), 32'd0);
      end else begin
        b = exp_q[0];
        check_val("out_data", 32'(bus.out_data), 32'(b.data));
        check_val("out_sop",  32'(bus.out_sop),  32'(b.sop));
        check_val("out_eop",  32'(bus.out_eop),  32'(b.eop));
        check_val("out_port", 32'(bus.out_port), 32'(b.port));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          if (nacc == 0) first_acc = cyc;
          last_acc = cyc;
          nacc++;
        end
      end
    end
    if (bus.pkt_done) n_done++;
    if (bus.err)      n_err++;
  endtask

  task automatic tick();
    logic [1:0] s;
    mon();
    @(posedge clk);
    cyc++;
    s = bus.fifo_strobe;
    if (s != 2'b00) check_val("strobe_onehot", 32'($countones(s)), 32'd1);
    if (s[0]) check_val("strobe0_avail", 32'(fq0.size() != 0), 32'd1);
    if (s[1]) check_val("strobe1_avail", 32'(fq1.size() != 0), 32'd1);
    #1;
    if (s[0] && fq0.size() != 0) begin void'(fq0.pop_front()); pops0++; end
    if (s[1] && fq1.size() != 0) begin void'(fq1.pop_front()); pops1++; end
    refresh();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!bus.busy && exp_q.size() == 0 && fq0.size() == 0 && fq1.size() == 0)
        done = 1'b1;
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fq0.delete();
    fq1.delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int   d0, e0, p0, p1;
    logic seen;
    logic [3:0] rpat;

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    refresh();
    @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check_val("rst_out_data",  32'(bus.out_data),    32'd0);
    check_val("rst_out_sop",   32'(bus.out_sop),     32'd0);
    check_val("rst_out_eop",   32'(bus.out_eop),     32'd0);
    check_val("rst_out_port",  32'(bus.out_port),    32'd0);
    check_val("rst_busy",      32'(bus.busy),        32'd0);
    check_val("rst_pkt_done",  32'(bus.pkt_done),    32'd0);
    check_val("rst_err",       32'(bus.err),         32'd0);
    check_val("rst_strobe",    32'(bus.fifo_strobe), 32'd0);
    tick();
    rst = 1'b0;

    // Single 3-byte packet on port 0 streams back-to-back.
    push_pkt(1'b0, 3, 8'hA1, 3, 1'b1);
    refresh();
    nacc = 0; d0 = n_done; p0 = pops0;
    wait_idle("t1_idle", 40);
    check_val("t1_beats",     nacc, 3);
    check_val("t1_span",      last_acc - first_acc, 2);
    check_val("t1_pkt_done",  n_done - d0, 1);
    check_val("t1_pops0",     pops0 - p0, 4);

    // Both ports from reset: port 0 first, then alternation repeats.
    do_reset();
    push_pkt(1'b0, 1, 8'hB0, 1, 1'b1);
    push_pkt(1'b1, 1, 8'hC0, 1, 1'b1);
    refresh();
    d0 = n_done;
    wait_idle("t2a_idle", 40);
    check_val("t2a_pkt_done", n_done - d0, 2);
    push_pkt(1'b0, 1, 8'hB1, 1, 1'b1);
    push_pkt(1'b1, 1, 8'hC1, 1, 1'b1);
    refresh();
    d0 = n_done;
    wait_idle("t2b_idle", 40);
    check_val("t2b_pkt_done", n_done - d0, 2);

    // Partial payload holds the packet until it is fully resident.
    push_pkt(1'b1, 4, 8'h30, 2, 1'b1);
    refresh();
    nacc = 0;
    repeat (10) tick();
    check_val("t3_no_beats", nacc, 0);
    check_val("t3_valid_lo", 32'(bus.out_valid), 32'd0);
    check_val("t3_busy",     32'(bus.busy), 32'd1);
    push_byte(1'b1, 8'h32);
    push_byte(1'b1, 8'h33);
    refresh();
    wait_idle("t3_idle", 40);
    check_val("t3_beats", nacc, 4);
    check_val("t3_span",  last_acc - first_acc, 3);

    // Zero-length header, oversize drop, and the largest accepted length.
    push_pkt(1'b0, 0, 8'h00, 0, 1'b0);
    refresh();
    d0 = n_done; p0 = pops0;
    wait_idle("t4z_idle", 20);
    check_val("t4z_pkt_done", n_done - d0, 1);
    check_val("t4z_pops0",    pops0 - p0, 1);
    push_pkt(1'b0, 20, 8'h50, 20, 1'b0);
    refresh();
    d0 = n_done; e0 = n_err; p0 = pops0;
    wait_idle("t4d_idle", 80);
    check_val("t4d_err",      n_err - e0, 1);
    check_val("t4d_pkt_done", n_done - d0, 1);
    check_val("t4d_pops0",    pops0 - p0, 21);
    push_pkt(1'b1, MAXL, 8'h60, MAXL, 1'b1);
    refresh();
    e0 = n_err; nacc = 0;
    wait_idle("t4m_idle", 80);
    check_val("t4m_err",   n_err - e0, 0);
    check_val("t4m_beats", nacc, MAXL);

    // Sink back-pressure mid-packet.
    bus.out_ready = 1'b0;
    push_pkt(1'b1, 4, 8'h70, 4, 1'b1);
    refresh();
    nacc = 0; p1 = pops1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.out_valid;
    end
    check_val("t5_valid_seen", 32'(seen), 32'd1);
    rpat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = rpat[3-i];
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle("t5_idle", 40);
    check_val("t5_beats", nacc, 4);
    check_val("t5_pops1", pops1 - p1, 5);

    // Reset in the middle of a 5-byte packet.
    push_pkt(1'b0, 5, 8'h80, 5, 1'b1);
    refresh();
    nacc = 0;
    for (int i = 0; i < 30 && nacc < 2; i++) tick();
    check_val("t6_two_beats", nacc, 2);
    check_val("t6_valid_pre", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_val("t6_valid_rst", 32'(bus.out_valid), 32'd0);
    check_val("t6_busy_rst",  32'(bus.busy), 32'd0);
    fq0.delete();
    fq1.delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    rst = 1'b0;
    push_pkt(1'b0, 1, 8'hA0, 1, 1'b1);
    push_pkt(1'b1, 2, 8'h90, 2, 1'b1);
    refresh();
    d0 = n_done;
    wait_idle("t6_idle", 40);
    check_val("t6_pkt_done", n_done - d0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
